// File: rtl/dbg_pkg.sv
// dbg_pkg: command bytes, op encodings and FSM states for the debug memory host
package dbg_pkg;
   localparam logic [7:0] CMD_A  = 8'h61;
   localparam logic [7:0] CMD_I  = 8'h69;
   localparam logic [7:0] CMD_W  = 8'h77;
   localparam logic [7:0] CMD_WW = 8'h57;
   localparam logic [7:0] CMD_R  = 8'h72;
   localparam logic [7:0] CMD_L  = 8'h6c;
   localparam logic [1:0] OP_STAT = 2'd0;
   localparam logic [1:0] OP_RDW  = 2'd1;
   localparam logic [1:0] OP_WRB  = 2'd2;
   localparam logic [1:0] OP_WRW  = 2'd3;
   typedef enum logic [3:0] {IDLE, A_CMD, A_HI, A_LO, CMD, D_HI, D_LO, RESP1, L_CMD, RESP2} state_t;
endpackage

// File: rtl/dbg_host.sv
// dbg_host: turns memory/status requests into the byte-serial debug command stream,
// skipping the address phase when the target's auto-incremented address already matches.
module dbg_host
   import dbg_pkg::*;
#(
   parameter int TMO_W = 16
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        req,
   input  logic [1:0]  op,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] rdata,
   output logic [7:0]  rstat,
   output logic [7:0]  txd,
   output logic        txv,
   input  logic        txrdy,
   input  logic [7:0]  rxd,
   input  logic        rxv
);
   state_t state, state_n;
   logic [1:0] l_op;
   logic [15:0] l_addr, l_wdata, sh_addr, a_in;
   logic sh_vld, acc, snd, rsp, tmo, fin;
   logic [TMO_W-1:0] cnt;
   logic [7:0] cmd_b, tx_byte;
   assign busy = state != IDLE;
   always_comb begin
      acc = txv && txrdy;
      rsp = state == RESP1 || state == RESP2;
      snd = state inside {A_CMD, A_HI, A_LO, CMD, D_HI, D_LO, L_CMD};
      // fires so that done lands after 2^TMO_W-1 silent cycles in the response state
      tmo = rsp && !rxv && cnt == {{(TMO_W-1){1'b1}}, 1'b0};
      a_in = op[0] ? {addr[15:1], 1'b0} : addr;
      cmd_b = l_op == OP_STAT ? CMD_I : l_op == OP_RDW ? CMD_R : l_op == OP_WRB ? CMD_W : CMD_WW;
      tx_byte = state == A_CMD ? CMD_A :
                state == A_HI  ? l_addr[15:8] :
                state == A_LO  ? l_addr[7:0] :
                state == CMD   ? cmd_b :
                state == D_HI  ? l_wdata[15:8] :
                state == D_LO  ? l_wdata[7:0] :
                state == L_CMD ? CMD_L : 8'h00;
      state_n = state;
      fin = 1'b0;
      case (state)
         IDLE:   if (req) state_n = (op == OP_STAT || (sh_vld && sh_addr == a_in)) ? CMD : A_CMD;
         A_CMD:  if (acc) state_n = A_HI;
         A_HI:   if (acc) state_n = A_LO;
         A_LO:   if (acc) state_n = CMD;
         CMD:    if (acc) state_n = l_op == OP_WRW ? D_HI : l_op == OP_WRB ? D_LO : RESP1;
         D_HI:   if (acc) state_n = D_LO;
         D_LO:   if (acc) begin
            state_n = IDLE;
            fin = 1'b1;
         end
         RESP1:  if (rxv) begin
            state_n = l_op == OP_RDW ? L_CMD : IDLE;
            fin = l_op != OP_RDW;
         end else if (tmo) state_n = IDLE;
         L_CMD:  if (acc) state_n = RESP2;
         RESP2:  if (rxv) begin
            state_n = IDLE;
            fin = 1'b1;
         end else if (tmo) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         done    <= 1'b0;
         err     <= 1'b0;
         txv     <= 1'b0;
         txd     <= 8'h00;
         rdata   <= 16'h0000;
         rstat   <= 8'h00;
         l_op    <= OP_STAT;
         l_addr  <= 16'h0000;
         l_wdata <= 16'h0000;
         sh_addr <= 16'h0000;
         sh_vld  <= 1'b0;
         cnt     <= '0;
      end else begin
         state <= state_n;
         done  <= fin || tmo;
         err   <= tmo;
         txv   <= snd && !acc;
         txd   <= snd && !acc ? tx_byte : 8'h00;
         cnt   <= rsp ? cnt + TMO_W'(1) : '0;
         if (state == IDLE && req) begin
            l_op    <= op;
            l_addr  <= a_in;
            l_wdata <= wdata;
         end
         if (state == RESP1 && rxv) begin
            if (l_op == OP_RDW) rdata[15:8] <= rxd;
            else rstat <= rxd;
         end
         if (state == RESP2 && rxv) rdata[7:0] <= rxd;
         if (fin && l_op != OP_STAT) begin
            sh_addr <= l_addr + (l_op == OP_WRB ? 16'd1 : 16'd2);
            sh_vld  <= 1'b1;
         end
         if (tmo) sh_vld <= 1'b0;
      end
   end
endmodule
